// File: rtl/nanci_pe_collector_if.sv
// Drain-side stream of the Nanci PE collector.
// Master drives word and valid; slave returns ready.
interface nanci_pe_collector_if #(
    parameter int W = 6
);
    logic [W-1:0] o_data;
    logic         o_valid;
    logic         i_ready;

    modport master (
        output o_data,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/nanci_pe_collector.sv
// Nanci mesh sorter: PE output-link collector (capture, buffer, drain).
// Optional order check built when NANCI_COLLECT_ORDER_CHECK_EN is defined.
module nanci_pe_collector #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 3,
    parameter int DEPTH      = 8,
    parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] MAX_INT = '1,
    parameter int TIMEOUT    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE,
    nanci_pe_collector_if.master             out_if,
    output logic [$clog2(DEPTH):0]           o_count,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_timeout,
    output logic                             o_order_err
);
    localparam int W  = ADDR_WIDTH + DATA_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [W-1:0]    mem [DEPTH];
    logic [CW-1:0]   count;
    logic [CW-1:0]   rd_ptr;
    logic [IW-1:0]   idle_cnt;
    logic            timeout_q;
    logic            word_vld;
    logic            start_ok;
    logic            cap_full;
    logic            cap_to;
    logic            can_load;
    logic            drain_end;

    // Handshake-derived control terms shared by FSM and datapath.
    always_comb begin
        word_vld  = (i_PE != MAX_INT);
        start_ok  = i_start && (state == S_IDLE || state == S_DONE);
        cap_full  = (state == S_CAPTURE) && word_vld
                    && (count == CW'(DEPTH - 1));
        cap_to    = (state == S_CAPTURE) && !word_vld
                    && (idle_cnt == IW'(TIMEOUT - 1));
        can_load  = !out_if.o_valid || out_if.i_ready;
        drain_end = (state == S_DRAIN) && can_load && (rd_ptr == count);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (i_start) state_nx = S_CAPTURE;
            S_CAPTURE: if (cap_full || cap_to) state_nx = S_DRAIN;
            S_DRAIN:   if (drain_end) state_nx = S_DONE;
            S_DONE:    if (i_start) state_nx = S_CAPTURE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Buffer storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (state == S_CAPTURE && word_vld)
            mem[count[AW-1:0]] <= i_PE;
    end

    // Counters, timeout flag and registered drain output stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count          <= '0;
            rd_ptr         <= '0;
            idle_cnt       <= '0;
            timeout_q      <= 1'b0;
            out_if.o_valid <= 1'b0;
            out_if.o_data  <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    out_if.o_valid <= 1'b0;
                    if (start_ok) begin
                        count     <= '0;
                        rd_ptr    <= '0;
                        idle_cnt  <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    if (word_vld) begin
                        count    <= count + CW'(1);
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                    if (cap_to) timeout_q <= 1'b1;
                end
                S_DRAIN: begin
                    if (can_load) begin
                        if (rd_ptr < count) begin
                            out_if.o_data  <= mem[rd_ptr[AW-1:0]];
                            out_if.o_valid <= 1'b1;
                            rd_ptr         <= rd_ptr + CW'(1);
                        end else begin
                            out_if.o_valid <= 1'b0;
                        end
                    end
                end
                default: out_if.o_valid <= 1'b0;
            endcase
        end
    end

`ifdef NANCI_COLLECT_ORDER_CHECK_EN
    logic [W-1:0] prev_q;
    logic         order_err_q;

    // Flag a stored word smaller than the one stored before it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q      <= '0;
            order_err_q <= 1'b0;
        end else if (start_ok) begin
            order_err_q <= 1'b0;
        end else if (state == S_CAPTURE && word_vld) begin
            if (count != '0 && i_PE < prev_q) order_err_q <= 1'b1;
            prev_q <= i_PE;
        end
    end

    assign o_order_err = order_err_q;
`else
    assign o_order_err = 1'b0;
`endif

    assign o_count   = count;
    assign o_busy    = (state == S_CAPTURE) || (state == S_DRAIN);
    assign o_done    = (state == S_DONE);
    assign o_timeout = timeout_q;
endmodule

// File: tb/tb_nanci_pe_collector.sv
// Self-checking bench for nanci_pe_collector.
// Reference model: queue of expected words built from the capture rules.
module tb_nanci_pe_collector;
    localparam int W       = 6;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam logic [W-1:0] MAXI = 6'h3F;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic [W-1:0] i_PE;
    logic [3:0]   o_count;
    logic         o_busy;
    logic         o_done;
    logic         o_timeout;
    logic         o_order_err;

    nanci_pe_collector_if #(.W(W)) bus ();

    nanci_pe_collector #(
        .ADDR_WIDTH(3),
        .DATA_WIDTH(3),
        .DEPTH(DEPTH),
        .MAX_INT(MAXI),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_start(i_start),
        .i_PE(i_PE),
        .out_if(bus),
        .o_count(o_count),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_timeout(o_timeout),
        .o_order_err(o_order_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] exp_q[$];
    int           m_count;
    bit           m_err;
    bit           m_to;

    function automatic bit exp_err();
`ifdef NANCI_COLLECT_ORDER_CHECK_EN
        return m_err;
`else
        return 1'b0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_start = 1'b0;
        i_PE = MAXI;
        bus.i_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        n_chk++;
        if ({bus.o_data, bus.o_valid, o_count, o_busy, o_done,
             o_timeout, o_order_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h v=%b cnt=%0d busy=%b done=%b to=%b oe=%b, want all 0",
                     bus.o_data, bus.o_valid, o_count, o_busy, o_done,
                     o_timeout, o_order_err);
        end
        i_PE = 6'b000101;
        for (int i = 0; i < 4; i++) begin
            step();
            n_chk++;
            if (o_count !== 4'd0 || o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_no_capture: got cnt=%0d busy=%b, want 0 0",
                         o_count, o_busy);
            end
        end
    endtask

    // Pulse start, then feed words (padding with idle) until the model
    // says capture has ended; checks count/order/busy every sample.
    task automatic capture(input logic [W-1:0] ws[$], input bit rnd_start);
        bit ended = 0;
        logic [W-1:0] w;
        logic [W-1:0] prev = '0;
        int idle = 0;
        exp_q.delete();
        m_count = 0;
        m_err = 0;
        m_to = 0;
        i_start = 1'b1;
        i_PE = 6'h01;
        step();
        i_start = 1'b0;
        n_chk++;
        if (o_busy !== 1'b1 || o_count !== 4'd0 || o_timeout !== 1'b0
            || o_order_err !== 1'b0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL start: got busy=%b cnt=%0d to=%b oe=%b done=%b, want 1 0 0 0 0",
                     o_busy, o_count, o_timeout, o_order_err, o_done);
        end
        for (int i = 0; i < 200 && !ended; i++) begin
            w = (i < ws.size()) ? ws[i] : MAXI;
            i_PE = w;
            i_start = rnd_start ? ($urandom_range(0, 5) == 0) : 1'b0;
            step();
            if (w != MAXI) begin
                if (m_count > 0 && w < prev) m_err = 1;
                prev = w;
                exp_q.push_back(w);
                m_count++;
                idle = 0;
                if (m_count == DEPTH) ended = 1;
            end else begin
                idle++;
                if (idle == TIMEOUT) begin
                    ended = 1;
                    m_to = 1;
                end
            end
            n_chk++;
            if (o_count !== 4'(m_count) || o_order_err !== exp_err()
                || o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL capture_step%0d: got cnt=%0d oe=%b busy=%b, want %0d %b 1",
                         i, o_count, o_order_err, o_busy, m_count, exp_err());
            end
        end
        i_start = 1'b0;
        i_PE = MAXI;
        n_chk++;
        if (!ended || o_timeout !== m_to) begin
            n_fail++;
            $display("FAIL capture_end: got to=%b ended=%b, want to=%b ended=1",
                     o_timeout, ended, m_to);
        end
    endtask

    // mode 0: ready high, 1: 1,0,0 pattern, 2: random. stop>0 returns
    // right after that many transfers have completed.
    task automatic drain(input int mode, input int stop);
        bit stall = 0;
        logic [W-1:0] held = '0;
        logic rdy;
        int got = 0;
        int cyc;
        for (cyc = 0; cyc < 300 && o_done !== 1'b1; cyc++) begin
            if (stall) begin
                n_chk++;
                if (bus.o_valid !== 1'b1 || bus.o_data !== held) begin
                    n_fail++;
                    $display("FAIL hold_stable: got v=%b d=%h, want 1 %h",
                             bus.o_valid, bus.o_data, held);
                end
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.i_ready = rdy;
            stall = 0;
            if (bus.o_valid === 1'b1) begin
                if (!rdy) begin
                    stall = 1;
                    held = bus.o_data;
                end else begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL drain_extra: got word %h, want none",
                                 bus.o_data);
                    end else begin
                        logic [W-1:0] e = exp_q.pop_front();
                        if (bus.o_data !== e) begin
                            n_fail++;
                            $display("FAIL drain_word%0d: got %h, want %h",
                                     got, bus.o_data, e);
                        end
                    end
                    got++;
                end
            end
            step();
            if (stop > 0 && got >= stop) return;
        end
        bus.i_ready = 1'b0;
        n_chk++;
        if (o_done !== 1'b1 || exp_q.size() != 0 || o_busy !== 1'b0
            || bus.o_valid !== 1'b0 || o_count !== 4'(m_count)
            || o_timeout !== m_to || o_order_err !== exp_err()) begin
            n_fail++;
            $display("FAIL drain_done: got done=%b left=%0d busy=%b v=%b cnt=%0d to=%b oe=%b, want 1 0 0 0 %0d %b %b",
                     o_done, exp_q.size(), o_busy, bus.o_valid, o_count,
                     o_timeout, o_order_err, m_count, m_to, exp_err());
        end
    endtask

    task automatic test_full_capture();
        logic [W-1:0] ws[$] = '{6'h01, 6'h05, 6'h0A, 6'h11,
                                6'h15, 6'h20, 6'h2A, 6'h3E};
        capture(ws, 0);
        drain(0, 0);
    endtask

    task automatic test_timeout();
        logic [W-1:0] ws[$] = '{6'h05, MAXI, MAXI, MAXI, 6'h07};
        capture(ws, 0);
        drain(0, 0);
    endtask

    task automatic test_empty();
        logic [W-1:0] ws[$];
        capture(ws, 0);
        drain(0, 0);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ws[$] = '{6'h02, 6'h03, 6'h09, 6'h0C,
                                6'h18, 6'h19, 6'h30, 6'h31};
        capture(ws, 0);
        drain(1, 0);
    endtask

    task automatic test_order_err();
        logic [W-1:0] ws[$] = '{6'h10, 6'h08};
        capture(ws, 0);
        drain(2, 0);
    endtask

    task automatic test_reset_mid_drain();
        logic [W-1:0] ws[$] = '{6'h04, 6'h06, 6'h08, 6'h0A,
                                6'h0B, 6'h0C, 6'h0D, 6'h0E};
        capture(ws, 0);
        drain(0, 3);
        rst = 1'b0;
        step();
        rst = 1'b1;
        n_chk++;
        if (bus.o_valid !== 1'b0 || o_count !== 4'd0 || o_busy !== 1'b0
            || o_done !== 1'b0 || o_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_drain: got v=%b cnt=%0d busy=%b done=%b to=%b, want 0",
                     bus.o_valid, o_count, o_busy, o_done, o_timeout);
        end
        capture(ws, 0);
        drain(0, 0);
    endtask

    task automatic test_random();
        logic [W-1:0] ws[$];
        for (int t = 0; t < 12; t++) begin
            ws.delete();
            for (int i = 0; i < $urandom_range(0, 14); i++) begin
                if ($urandom_range(0, 9) < 3) ws.push_back(MAXI);
                else ws.push_back(W'($urandom_range(0, 62)));
            end
            capture(ws, 1);
            drain(int'($urandom_range(0, 2)), 0);
        end
    endtask

    initial begin
        test_reset();
        test_full_capture();
        test_timeout();
        test_empty();
        test_backpressure();
        test_order_err();
        test_reset_mid_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/nanci_pe_collector.md
# nanci_pe_collector

Receiving end of a PE output link (`o_PE`) in the Nanci mesh sorter. The block samples `{addr,data}` words that a PE drives after its sort/compute phase and discards idle (`MAX_INT`) words. It buffers up to `DEPTH` valid words, optionally checks that they arrive in non-decreasing order, then streams them out over a valid/ready handshake to the host/result side. One instance sits on each row-end PE, or on the single PE in unit benches.

## Interface
Parameters:
- `ADDR_WIDTH`, 3, address field width of a link word
- `DATA_WIDTH`, 3, data field width of a link word
- `DEPTH`, 8, buffer entries; power of two, ≥2
- `MAX_INT`, all ones (`ADDR_WIDTH+DATA_WIDTH` bits), idle/sentinel word, never stored
- `TIMEOUT`, 16, consecutive idle cycles in CAPTURE that end capture early

Ports:
- `clk` in 1, single clock, rising edge
- `rst` in 1, synchronous, active-low reset
- `i_start` in 1, pulse; begins capture (honoured only in IDLE or DONE)
- `i_PE` in `ADDR_WIDTH+DATA_WIDTH`, word from PE `o_PE`
- `o_data` out `ADDR_WIDTH+DATA_WIDTH`, drained word
- `o_valid` out 1, `o_data` valid
- `i_ready` in 1, consumer accepts `o_data`
- `o_count` out `$clog2(DEPTH)+1`, words captured
- `o_busy` out 1, high in CAPTURE or DRAIN
- `o_done` out 1, high in DONE
- `o_timeout` out 1, sticky; capture ended by TIMEOUT
- `o_order_err` out 1, sticky; ordering violation seen

## Operation
- States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE: outputs quiescent. `i_start` → CAPTURE; clear count, read pointer, idle counter, `o_timeout`, `o_order_err`.
- CAPTURE: each cycle, if `i_PE != MAX_INT`, write it to `buf[count]`, increment count, and zero the idle counter. Otherwise increment the idle counter.
- CAPTURE → DRAIN when count reaches `DEPTH`, which includes the cycle the `DEPTH`th word is written.
- CAPTURE → DRAIN when the idle counter reaches `TIMEOUT`. Set `o_timeout`.
- DRAIN with count 0 goes to DONE on the next cycle and `o_valid` never asserts.
- DRAIN: `o_data = buf[rd_ptr]` and `o_valid = 1` while `rd_ptr < count`.
- A transfer occurs on a cycle with `o_valid && i_ready`; it increments `rd_ptr`. After the last transfer, go to DONE.
- `o_data` and `o_valid` must not change while `o_valid && !i_ready`.
- DONE: `o_done = 1`. `o_count` holds the final count. `i_start` restarts capture.
- `i_start` in CAPTURE or DRAIN is ignored.
- Order check compares whole words, unsigned. A word smaller than the previously stored word sets `o_order_err`. The first word is never an error.
- Reset (`rst == 0`) in any state, including mid-capture or mid-drain, forces IDLE on the next edge. Buffer contents are don't-care after reset.

## Timing
- Reset values: `o_data = 0`, `o_valid = 0`, `o_count = 0`, `o_busy = 0`, `o_done = 0`, `o_timeout = 0`, `o_order_err = 0`.
- `i_start` sampled at edge N → CAPTURE from N; first `i_PE` sample at edge N+1.
- Capture latency: word at edge K is visible in `o_count` after K.
- First `o_valid` on the cycle after entering DRAIN. Throughput is 1 word/cycle with `i_ready` held high.
- `o_order_err` rises the cycle after the offending sample.

## Configuration
- `NANCI_COLLECT_ORDER_CHECK_EN` defined: previous-word register and comparator are built; `o_order_err` behaves as above.
- Not defined: no comparator; `o_order_err` is tied 0. All other behaviour is identical.

## Test plan
- Reset/idle: hold `rst = 0` for 2 cycles, then release. All outputs 0, state IDLE; `i_PE = 6'b000101` without `i_start` → `o_count` stays 0.
- Full capture + drain: start, then feed 0x01, 0x05, 0x0A, 0x11, 0x15, 0x20, 0x2A, 0x3E. Expect `o_count = 8` and DRAIN. With `i_ready = 1`, the same 8 words appear in order on consecutive cycles, then `o_done = 1` and `o_order_err = 0`.
- Idle filtering + timeout: feed 0x05, `MAX_INT` ×3, 0x07, then `MAX_INT` ×16. Expect `o_count = 2`, `o_timeout = 1`, and drain outputs 0x05, 0x07.
- Backpressure: during drain toggle `i_ready` 1,0,0,1,… `o_data` is held stable while not ready, and no word is dropped or duplicated.
- Order error (macro defined): feed 0x10, 0x08, then timeout. `o_order_err = 1` the cycle after 0x08. Without the macro, `o_order_err` stays 0.
- Reset mid-drain: assert `rst = 0` after 3 transfers → IDLE next edge, `o_valid = 0`, `o_count = 0`. A new `i_start` captures normally.
